// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and helpers for the sequential 32-to-5
// round-robin encoder (encoder32x5_rr).
package encoder_pkg;

  localparam int NUM_IN = 32;
  localparam int IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic popcount_gt1(input logic [NUM_IN-1:0] v);
    return (v & (v - {{(NUM_IN-1){1'b0}}, 1'b1})) != '0;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Combinational round-robin pick: lowest set bit at or above ptr, falling back
// to the lowest set bit overall when nothing at or above ptr is pending.
module rr_find_first
  import encoder_pkg::*;
(
  input  logic [NUM_IN-1:0] pending,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  sel,
  output logic              any
);

  logic [NUM_IN-1:0] masked;
  logic              any_masked;

  function automatic logic [IDX_W-1:0] lsb_index(input logic [NUM_IN-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign masked     = pending & ({NUM_IN{1'b1}} << ptr);
  assign any_masked = |masked;
  assign any        = |pending;
  assign sel        = any_masked ? lsb_index(masked) : lsb_index(pending);

endmodule

// File: rtl/encoder32x5_rr.sv
// Sequential 32-to-5 encoder: sticky request capture, round-robin grant, valid/ready output.
// Build option: define ENCODER32X5_ACTIVE_LOW_IN_EN to treat req as active-low.
module encoder32x5_rr
  import encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_IN-1:0] req,
  input  logic              ready,
  output logic              valid,
  output logic [IDX_W-1:0]  idx,
  output logic              multi,
  output logic              busy
);

  state_t             state, state_nxt;
  logic [NUM_IN-1:0]  pending, pending_nxt;
  logic [NUM_IN-1:0]  req_act, set_mask, clr_mask;
  logic [IDX_W-1:0]   ptr, ptr_nxt, idx_nxt;
  logic               valid_nxt, multi_nxt;
  logic [IDX_W-1:0]   sel;
  logic               any;

`ifdef ENCODER32X5_ACTIVE_LOW_IN_EN
  assign req_act = ~req;
`else
  assign req_act = req;
`endif

  rr_find_first u_find (
    .pending (pending),
    .ptr     (ptr),
    .sel     (sel),
    .any     (any)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    valid_nxt = valid;
    multi_nxt = multi;
    clr_mask  = '0;

    unique case (state)
      IDLE: begin
        if (any) begin
          idx_nxt   = sel;
          multi_nxt = popcount_gt1(pending);
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (valid && ready) begin
          clr_mask  = {{(NUM_IN-1){1'b0}}, 1'b1} << idx;
          ptr_nxt   = idx + IDX_W'(1);
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Set is applied after clear so a fresh request on the granted line survives.
    set_mask    = en ? req_act : '0;
    pending_nxt = (pending & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      ptr     <= '0;
      idx     <= '0;
      valid   <= 1'b0;
      multi   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      valid   <= valid_nxt;
      multi   <= multi_nxt;
    end
  end

  assign busy = |pending;

endmodule

// File: tb/tb_encoder32x5_rr.sv
// Self-checking bench for encoder32x5_rr: per-cycle comparison against a behavioural
// model plus directed vectors with literal expectations. Honours ENCODER32X5_ACTIVE_LOW_IN_EN.
module tb_encoder32x5_rr;

  logic        clk = 1'b0;
  logic        rst, en, ready;
  logic [31:0] lreq;
  logic [31:0] req;
  logic        valid, multi, busy;
  logic [4:0]  idx;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ENCODER32X5_ACTIVE_LOW_IN_EN
  assign req = ~lreq;
`else
  assign req = lreq;
`endif

  encoder32x5_rr dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .req   (req),
    .ready (ready),
    .valid (valid),
    .idx   (idx),
    .multi (multi),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of pending lines, a rotating start point and
  // the currently offered grant.
  bit [31:0] m_pending;
  int        m_ptr;
  bit        m_valid;
  int        m_idx;
  bit        m_multi;
  bit        started = 1'b0;

  function automatic int rr_pick(input bit [31:0] p, input int start);
    for (int i = 0; i < 32; i++) begin
      if (p[(start + i) % 32]) return (start + i) % 32;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    bit [31:0] old_p;
    if (rst) begin
      m_pending = '0; m_ptr = 0; m_valid = 0; m_idx = 0; m_multi = 0;
      started = 1'b1;
    end else begin
      old_p = m_pending;
      if (m_valid) begin
        if (ready) begin
          m_pending[m_idx] = 1'b0;
          m_ptr   = (m_idx + 1) % 32;
          m_valid = 0;
        end
      end else if (old_p != 0) begin
        m_idx   = rr_pick(old_p, m_ptr);
        m_multi = ($countones(old_p) > 1);
        m_valid = 1;
      end
      if (en) m_pending = m_pending | lreq;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_busy", 32'(busy), 32'(m_pending != 0));
      if (m_valid) begin
        check("model_idx", 32'(idx), 32'(m_idx));
        check("model_multi", 32'(multi), 32'(m_multi));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for valid, then checks the offered index and multi flag.
  task automatic wait_valid(input string name, input int exp_idx, input bit exp_multi);
    int waited = 0;
    while (valid !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    check({name, "_valid"}, 32'(valid), 32'd1);
    check({name, "_idx"}, 32'(idx), 32'(exp_idx));
    check({name, "_multi"}, 32'(multi), 32'(exp_multi));
  endtask

  task automatic pulse_req(input logic [31:0] v);
    lreq = v;
    cyc();
    lreq = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cyc(n);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ready = 1'b1; lreq = '0;
    cyc(2);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_idx", 32'(idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_multi", 32'(multi), 32'd0);
    rst = 1'b0;

    // Single request: pending after edge k, valid after edge k+1.
    pulse_req(32'h0000_0100);
    check("single_busy_k", 32'(busy), 32'd1);
    check("single_novalid_k", 32'(valid), 32'd0);
    cyc();
    check("single_valid_k1", 32'(valid), 32'd1);
    wait_valid("single", 8, 1'b0);
    cyc();
    check("single_drop_valid", 32'(valid), 32'd0);
    check("single_drop_busy", 32'(busy), 32'd0);

    // Round-robin order from ptr=0.
    do_reset(1);
    pulse_req(32'h8000_0011);
    wait_valid("rr0", 0, 1'b1);  cyc();
    wait_valid("rr4", 4, 1'b1);  cyc();
    wait_valid("rr31", 31, 1'b0); cyc();
    pulse_req(32'h0000_0001);
    wait_valid("rr_wrap", 0, 1'b0); cyc();

    // Backpressure: grant held stable while ready=0; new request accumulates.
    ready = 1'b0;
    pulse_req(32'h0000_0008);
    wait_valid("hold", 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      lreq = (i == 1) ? 32'h0000_0002 : 32'h0;
      cyc();
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_idx", 32'(idx), 32'd3);
      check("hold_multi", 32'(multi), 32'd0);
    end
    lreq = '0;
    ready = 1'b1;
    cyc();
    wait_valid("after_hold", 1, 1'b0); cyc();

    // Set-wins collision: bit 5 re-requested in its own accept cycle.
    ready = 1'b0;
    pulse_req(32'h0000_0220);
    wait_valid("coll5", 5, 1'b1);
    lreq = 32'h0000_0020;
    ready = 1'b1;
    cyc();
    lreq = '0;
    wait_valid("coll9", 9, 1'b1); cyc();
    wait_valid("coll5b", 5, 1'b0); cyc();

    // Enable gating, then reset while holding a grant.
    en = 1'b0;
    lreq = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("en0_valid", 32'(valid), 32'd0);
      check("en0_busy", 32'(busy), 32'd0);
    end
    ready = 1'b0;
    en = 1'b1;
    cyc();
    en = 1'b0;
    lreq = '0;
    wait_valid("en1_grant", 6, 1'b1);
    do_reset(1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_idx", 32'(idx), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    en = 1'b1;
    ready = 1'b1;

    // Line 2 (physical FFFF_FFFB in the active-low build); idle input grants nothing.
    pulse_req(32'h0000_0004);
    wait_valid("line2", 2, 1'b0); cyc();
    cyc(3);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
